// File: rtl/data_mem_master_if.sv
// Bus bundle for data_mem_master: datapath command/store/load streams plus the
// data_mem port (addr, MW, data_in, out). master = data_mem_master, slave = peer side.
interface data_mem_master_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic          mem_MW;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, mem_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, err, mem_addr, mem_MW, mem_data_in
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, mem_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, err, mem_addr, mem_MW, mem_data_in
  );
endinterface

// File: rtl/data_mem_master.sv
// Burst load/store sequencer driving data_mem; read data returned as a stream.
// Optional macro DATA_MEM_MASTER_BOUND_CHECK_EN rejects bursts that would wrap past 2^AW-1.
module data_mem_master #(
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int RD_LAT = 0
) (
  input  logic              CLK,
  input  logic              reset,
  data_mem_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      len_q, len_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [RD_LAT:0] tag_q, tag_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_mw_q, mem_mw_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;

`ifdef DATA_MEM_MASTER_BOUND_CHECK_EN
  logic [AW:0] end_addr;
  assign end_addr = {1'b0, bus.cmd_addr} + (AW+1)'(bus.cmd_len);
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q << 1;
    rd_valid_d = tag_q[RD_LAT];
    rd_data_d  = tag_q[RD_LAT] ? bus.mem_out : rd_data_q;
    err_d      = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_mw_d   = 1'b0;
    mem_din_d  = mem_din_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          len_d  = bus.cmd_len;
          cnt_d  = 3'd0;
`ifdef DATA_MEM_MASTER_BOUND_CHECK_EN
          if (end_addr[AW]) err_d = 1'b1;
          else              state_d = bus.cmd_write ? S_WR : S_RD;
`else
          state_d = bus.cmd_write ? S_WR : S_RD;
`endif
        end
      end
      S_WR: begin
        // Bubbles (wr_valid=0) hold the address and drop MW for that cycle.
        if (bus.wr_valid) begin
          mem_addr_d = addr_q;
          mem_din_d  = bus.wr_data;
          mem_mw_d   = 1'b1;
          addr_d     = addr_q + AW'(1);
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == len_q) state_d = S_DONE;
        end
      end
      S_RD: begin
        mem_addr_d = addr_q;
        tag_d[0]   = 1'b1;
        addr_d     = addr_q + AW'(1);
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == len_q) state_d = S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        if (tag_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_mw_q   <= 1'b0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_mw_q   <= mem_mw_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign bus.cmd_ready   = (state_q == S_IDLE) && reset;
  assign bus.wr_ready    = (state_q == S_WR);
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_MW      = mem_mw_q;
  assign bus.mem_data_in = mem_din_q;

endmodule

// File: tb/tb_data_mem_master.sv
// Scoreboard bench for data_mem_master: RD_LAT=0 and RD_LAT=1 instances share one
// stimulus stream, each backed by its own data_mem model.
module tb_data_mem_master;
  localparam int AW = 6;
  localparam int DW = 32;
  typedef logic [AW+DW-1:0] wr_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  data_mem_master_if #(.AW(AW), .DW(DW)) b0 ();
  data_mem_master_if #(.AW(AW), .DW(DW)) b1 ();

  data_mem_master #(.AW(AW), .DW(DW), .RD_LAT(0)) dut0 (.CLK(CLK), .reset(reset), .bus(b0.master));
  data_mem_master #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (.CLK(CLK), .reset(reset), .bus(b1.master));

  assign b1.cmd_valid = b0.cmd_valid;
  assign b1.cmd_write = b0.cmd_write;
  assign b1.cmd_addr  = b0.cmd_addr;
  assign b1.cmd_len   = b0.cmd_len;
  assign b1.wr_valid  = b0.wr_valid;
  assign b1.wr_data   = b0.wr_data;

  // data_mem models: combinational read for dut0, one-cycle registered read for dut1
  logic [DW-1:0] mem0 [64];
  logic [DW-1:0] mem1 [64];
  logic [DW-1:0] out1_q;
  always @(posedge CLK) if (b0.mem_MW) mem0[b0.mem_addr] <= b0.mem_data_in;
  always @(posedge CLK) if (b1.mem_MW) mem1[b1.mem_addr] <= b1.mem_data_in;
  always @(posedge CLK) out1_q <= mem1[b1.mem_addr];
  assign b0.mem_out = mem0[b0.mem_addr];
  assign b1.mem_out = out1_q;

  logic [DW-1:0] ref_mem [64];
  wr_t           exp_wr0[$], exp_wr1[$];
  logic [DW-1:0] exp_rd0[$], exp_rd1[$];
  wr_t           w0, w1;
  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int done_cnt0 = 0, done_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0;
  int rd_first0 = -1, rd_first1 = -1, rd_last0 = -1, rd_last1 = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitors: pop expectations as the DUTs produce memory writes and load data.
  always @(negedge CLK) begin
    if (b0.mem_MW) begin
      if (exp_wr0.size() == 0) check("mw_unexpected0", 64'd1, 64'd0);
      else begin
        w0 = exp_wr0.pop_front();
        check("mw_addr0", 64'(b0.mem_addr), 64'(w0[AW+DW-1:DW]));
        check("mw_data0", 64'(b0.mem_data_in), 64'(w0[DW-1:0]));
      end
    end
    if (b0.rd_valid) begin
      if (exp_rd0.size() == 0) check("rd_unexpected0", 64'd1, 64'd0);
      else check("rd_data0", 64'(b0.rd_data), 64'(exp_rd0.pop_front()));
      if (rd_first0 < 0) rd_first0 = cyc;
      rd_last0 = cyc;
    end
    if (b0.done) done_cnt0++;
    if (b0.err) err_cnt0++;
  end

  always @(negedge CLK) begin
    if (b1.mem_MW) begin
      if (exp_wr1.size() == 0) check("mw_unexpected1", 64'd1, 64'd0);
      else begin
        w1 = exp_wr1.pop_front();
        check("mw_addr1", 64'(b1.mem_addr), 64'(w1[AW+DW-1:DW]));
        check("mw_data1", 64'(b1.mem_data_in), 64'(w1[DW-1:0]));
      end
    end
    if (b1.rd_valid) begin
      if (exp_rd1.size() == 0) check("rd_unexpected1", 64'd1, 64'd0);
      else check("rd_data1", 64'(b1.rd_data), 64'(exp_rd1.pop_front()));
      if (rd_first1 < 0) rd_first1 = cyc;
      rd_last1 = cyc;
    end
    if (b1.done) done_cnt1++;
    if (b1.err) err_cnt1++;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(b0.cmd_ready && b1.cmd_ready) && n < 50) begin tick(); n++; end
    check("idle_timeout", 64'(n < 50), 64'd1);
  endtask

  task automatic wait_done(input int n0, input int n1);
    int n = 0;
    while (!(done_cnt0 >= n0 && done_cnt1 >= n1) && n < 60) begin tick(); n++; end
    check("done_timeout", 64'(n < 60), 64'd1);
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [2:0] len, output int acc);
    wait_idle();
    b0.cmd_write = wr; b0.cmd_addr = a; b0.cmd_len = len; b0.cmd_valid = 1'b1;
    tick();
    acc = cyc;
    b0.cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    check("wr_ready", 64'(b0.wr_ready && b1.wr_ready), 64'd1);
    b0.wr_valid = 1'b1; b0.wr_data = wd;
    exp_wr0.push_back({wa, wd}); exp_wr1.push_back({wa, wd});
    ref_mem[wa] = wd;
    tick();
    b0.wr_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [2:0] len, input logic [DW-1:0] base, input int bubble);
    int acc;
    int d0 = done_cnt0, d1 = done_cnt1;
    send_cmd(1'b1, a, len, acc);
    for (int i = 0; i <= int'(len); i++) begin
      drive_beat(a + AW'(i), base + DW'(i));
      if (i == bubble) tick();
    end
    wait_done(d0 + 1, d1 + 1);
    check("wr_left", 64'(exp_wr0.size() + exp_wr1.size()), 64'd0);
  endtask

  task automatic push_reads(input logic [AW-1:0] a, input logic [2:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      exp_rd0.push_back(ref_mem[a + AW'(i)]);
      exp_rd1.push_back(ref_mem[a + AW'(i)]);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [2:0] len);
    int acc;
    int d0 = done_cnt0, d1 = done_cnt1;
    push_reads(a, len);
    rd_first0 = -1; rd_first1 = -1;
    send_cmd(1'b0, a, len, acc);
    wait_done(d0 + 1, d1 + 1);
    check("rd_lat0", 64'(rd_first0), 64'(acc + 2));
    check("rd_lat1", 64'(rd_first1), 64'(acc + 3));
    check("rd_burst0", 64'(rd_last0 - rd_first0), 64'(len));
    check("rd_burst1", 64'(rd_last1 - rd_first1), 64'(len));
    check("rd_left", 64'(exp_rd0.size() + exp_rd1.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready0", 64'(b0.cmd_ready), 64'd0);
    check("rst_cmd_ready1", 64'(b1.cmd_ready), 64'd0);
    check("rst_wr_ready0", 64'(b0.wr_ready), 64'd0);
    check("rst_rd_valid0", 64'(b0.rd_valid), 64'd0);
    check("rst_rd_data0", 64'(b0.rd_data), 64'd0);
    check("rst_done0", 64'(b0.done), 64'd0);
    check("rst_err0", 64'(b0.err), 64'd0);
    check("rst_mem_addr0", 64'(b0.mem_addr), 64'd0);
    check("rst_mem_mw0", 64'(b0.mem_MW), 64'd0);
    check("rst_mem_din0", 64'(b0.mem_data_in), 64'd0);
    check("rst_mem_mw1", 64'(b1.mem_MW), 64'd0);
    check("rst_mem_addr1", 64'(b1.mem_addr), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, d0, d1, e0, e1, ds0, ds1;
    bit acc0, acc1;
    b0.cmd_valid = 1'b0; b0.cmd_write = 1'b0; b0.cmd_addr = '0; b0.cmd_len = '0;
    b0.wr_valid = 1'b0; b0.wr_data = '0;

    // Reset values, then ready after release
    tick(); tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();
    check("ready_after_rst0", 64'(b0.cmd_ready), 64'd1);
    check("ready_after_rst1", 64'(b1.cmd_ready), 64'd1);

    // Single store and load-back
    do_write(6'd1, 3'd0, 32'h56, -1);
    do_read(6'd1, 3'd0);

    // Burst store with a bubble after beat 2, then burst load
    do_write(6'd2, 3'd3, 32'h25, 1);
    do_read(6'd2, 3'd3);

    // Burst across the top of the address space
`ifdef DATA_MEM_MASTER_BOUND_CHECK_EN
    e0 = err_cnt0; e1 = err_cnt1; d0 = done_cnt0; d1 = done_cnt1;
    send_cmd(1'b1, 6'd62, 3'd3, acc);
    repeat (4) tick();
    send_cmd(1'b0, 6'd62, 3'd3, acc);
    repeat (4) tick();
    check("oob_err0", 64'(err_cnt0 - e0), 64'd2);
    check("oob_err1", 64'(err_cnt1 - e1), 64'd2);
    check("oob_done0", 64'(done_cnt0 - d0), 64'd0);
    check("oob_done1", 64'(done_cnt1 - d1), 64'd0);
    check("oob_ready", 64'(b0.cmd_ready && b1.cmd_ready), 64'd1);
`else
    do_write(6'd62, 3'd3, 32'h99, -1);
    do_read(6'd62, 3'd3);
`endif

    // Reset after 2 of 8 store beats
    d0 = done_cnt0; d1 = done_cnt1;
    send_cmd(1'b1, 6'd10, 3'd7, acc);
    drive_beat(6'd10, 32'hA0);
    drive_beat(6'd11, 32'hA1);
    b0.wr_valid = 1'b1; b0.wr_data = 32'hDEAD;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("ready_after_abort0", 64'(b0.cmd_ready), 64'd1);
    check("ready_after_abort1", 64'(b1.cmd_ready), 64'd1);
    b0.wr_valid = 1'b0;
    repeat (2) tick();
    check("abort_no_done", 64'((done_cnt0 - d0) + (done_cnt1 - d1)), 64'd0);
    check("abort_wr_left", 64'(exp_wr0.size() + exp_wr1.size()), 64'd0);

    // Command held valid during a read burst
    d0 = done_cnt0; d1 = done_cnt1;
    push_reads(6'd2, 3'd3);
    push_reads(6'd1, 3'd0);
    wait_idle();
    b0.cmd_write = 1'b0; b0.cmd_addr = 6'd2; b0.cmd_len = 3'd3; b0.cmd_valid = 1'b1;
    tick();
    b0.cmd_addr = 6'd1; b0.cmd_len = 3'd0;
    acc0 = 1'b0; acc1 = 1'b0; ds0 = -100; ds1 = -100;
    for (int i = 0; i < 40 && !(acc0 && acc1); i++) begin
      if (!acc0) begin
        if (b0.done) ds0 = cyc;
        if (b0.cmd_ready) begin acc0 = 1'b1; check("busy_gap0", 64'(cyc), 64'(ds0 + 1)); end
      end
      if (!acc1) begin
        if (b1.done) ds1 = cyc;
        if (b1.cmd_ready) begin acc1 = 1'b1; check("busy_gap1", 64'(cyc), 64'(ds1 + 1)); end
      end
      if (!(acc0 && acc1)) tick();
    end
    tick();
    b0.cmd_valid = 1'b0;
    check("busy_accept", 64'(acc0 && acc1), 64'd1);
    wait_done(d0 + 2, d1 + 2);
    check("busy_rd_left", 64'(exp_rd0.size() + exp_rd1.size()), 64'd0);

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_wr0.size() + exp_wr1.size() + exp_rd0.size() + exp_rd1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
Initiator side of the data memory port. Accepts single-word or burst (1-8 word) load/store commands from the datapath and sequences the memory address, MW and data_in signals. It captures the memory's out bus and returns read data as a stream. It sits between the RISC datapath/control and data_mem, owning every cycle of memory traffic.

Parameters:
AW, 6, memory word-address width (64 words)
DW, 32, data width
RD_LAT, 0, memory read latency in cycles from address presented to out valid (0 = combinational read); legal 0..2

Ports:
CLK  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_write  input  1  1 = store burst, 0 = load burst
cmd_addr  input  AW  start word address
cmd_len  input  3  burst length minus one (0 = 1 word, 7 = 8 words)
wr_valid  input  1  store data beat offered
wr_ready  output  1  store beat accepted when wr_valid & wr_ready
wr_data  input  DW  store data
rd_valid  output  1  one-cycle pulse per returned load word (no backpressure)
rd_data  output  DW  load data, valid while rd_valid=1
done  output  1  one-cycle pulse after the last beat of a command completes
err  output  1  one-cycle pulse on rejected command (optional feature only; tied 0 otherwise)
mem_addr  output  AW  to data_mem addr
mem_MW  output  1  to data_mem MW
mem_data_in  output  DW  to data_mem data_in
mem_out  input  DW  from data_mem out

Behaviour:
- Reset (reset=0, async): state IDLE; cmd_ready=0 while in reset, 1 in IDLE after release; wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0, mem_addr=0, mem_MW=0, mem_data_in=0; beat counter, read-valid pipeline cleared. Reset mid-burst abandons it; no further MW pulses.
- All outputs registered except cmd_ready and wr_ready (decoded from state).
- States: IDLE, WR, RD, RD_DRAIN, DONE.
- IDLE: cmd_ready=1. On accept latch addr, len, write; go WR (write) or RD (read). mem_MW=0.
- WR: wr_ready=1. Each accepted beat at edge N: mem_addr<=cur addr, mem_data_in<=wr_data, mem_MW<=1 for cycle N..N+1 (memory commits at edge N+1). Cycles with wr_valid=0: mem_MW<=0, no address advance (bubbles allowed). After beat len+1 accepted -> DONE.
- RD: one address issued per cycle, mem_addr<=cur addr, mem_MW<=0, for len+1 cycles, then RD_DRAIN. A valid-tag shift pipeline of depth RD_LAT+1 tracks issued reads; address issued at edge N yields rd_valid=1, rd_data=mem_out at edge N+1+RD_LAT.
- RD_DRAIN: wait until tag pipeline empty -> DONE.
- DONE: done=1 for exactly one cycle, cmd_ready=0, -> IDLE. Minimum command-to-command spacing one idle cycle.
- Address arithmetic: cur addr increments by 1 mod 2^AW per beat; burst starting at 62 len 3 touches 62,63,0,1.
- cmd_valid outside IDLE ignored (cmd_ready=0). wr_valid outside WR ignored.
- mem_MW never asserted in RD/RD_DRAIN/IDLE; write and read never overlap.

Optional Feature:
Macro DATA_MEM_MASTER_BOUND_CHECK_EN. Defined: command with cmd_addr+cmd_len > 2^AW-1 is accepted (cmd_ready handshake completes) but not executed; err pulses one cycle, next state DONE-free return to IDLE (done stays 0, no mem_MW, no rd_valid). Undefined: address wraps as above; err tied 0.

Test Plan:
- Single store: reset, cmd write addr=1 len=0, wr_data=0x56 -> mem_MW=1 one cycle with mem_addr=1, mem_data_in=0x56; done pulse; then load addr=1 -> rd_valid once with rd_data=0x56.
- Burst store/load: write addr=2 len=3 data 0x25,0x26,0x27,0x28 with a wr_valid bubble after beat 2 -> 4 MW cycles at addrs 2..5; read back len=3 -> 4 consecutive rd_valid pulses in order, RD_LAT=0 and RD_LAT=1 both checked.
- Wrap: write addr=62 len=3 data 0x99.. -> mem_addr sequence 62,63,0,1; read back matches (macro undefined); with macro defined -> err=1 one cycle, no MW, done=0.
- Reset mid-burst: assert reset after 2 of 8 write beats -> outputs return to reset values immediately, no further mem_MW, IDLE after release, cmd_ready=1.
- Command while busy: cmd_valid held during read burst -> cmd_ready=0 until after done; second command accepted in following IDLE cycle.
